// File: rtl/power_pulsing_pkg.sv
// Shared state type, output bundle and default delays for the power-pulsing sequencer.
// Define POWER_PULSING_ADC_EN to include the ADC rail stage (UP_ADC).
package power_pulsing_pkg;

    localparam int unsigned CNT_W_DEF = 16;
    localparam int unsigned T_DIG_DEF = 400;
    localparam int unsigned T_ANA_DEF = 2000;
    localparam int unsigned T_DAC_DEF = 400;
    localparam int unsigned T_ADC_DEF = 400;
    localparam int unsigned T_OFF_DEF = 1000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UP_DIG,
        ST_UP_ANA,
        ST_UP_DAC,
`ifdef POWER_PULSING_ADC_EN
        ST_UP_ADC,
`endif
        ST_READY,
        ST_OFF
    } pp_state_e;

    typedef struct packed {
        logic dig;
        logic ana;
        logic dac;
        logic adc;
        logic ready;
        logic busy;
    } pp_out_t;

    // Cumulative rail pattern for each state; IDLE and OFF keep every rail off.
    function automatic pp_out_t outputs_of(input pp_state_e st);
        pp_out_t o;
        o = '0;
        case (st)
            ST_UP_DIG: begin
                o.dig  = 1'b1;
                o.busy = 1'b1;
            end
            ST_UP_ANA: begin
                o.dig  = 1'b1;
                o.ana  = 1'b1;
                o.busy = 1'b1;
            end
            ST_UP_DAC: begin
                o.dig  = 1'b1;
                o.ana  = 1'b1;
                o.dac  = 1'b1;
                o.busy = 1'b1;
            end
`ifdef POWER_PULSING_ADC_EN
            ST_UP_ADC: begin
                o.dig  = 1'b1;
                o.ana  = 1'b1;
                o.dac  = 1'b1;
                o.adc  = 1'b1;
                o.busy = 1'b1;
            end
`endif
            ST_READY: begin
                o.dig   = 1'b1;
                o.ana   = 1'b1;
                o.dac   = 1'b1;
`ifdef POWER_PULSING_ADC_EN
                o.adc   = 1'b1;
`endif
                o.ready = 1'b1;
            end
            ST_OFF:  o.busy = 1'b1;
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/pp_delay_counter.sv
// Loadable down-counter shared by every timed state; holds at zero and flags done there.
module pp_delay_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] count;

    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/power_pulsing_sequencer.sv
// Staggered power-up / forced-off-time sequencer for the ASIC power-pulsing rails.
// Define POWER_PULSING_ADC_EN to sequence the ADC rail; otherwise DAC settles straight into READY.
module power_pulsing_sequencer
    import power_pulsing_pkg::*;
#(
    parameter int unsigned T_DIG = T_DIG_DEF,
    parameter int unsigned T_ANA = T_ANA_DEF,
    parameter int unsigned T_DAC = T_DAC_DEF,
    parameter int unsigned T_ADC = T_ADC_DEF,
    parameter int unsigned T_OFF = T_OFF_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic Clk,
    input  logic reset,
    input  logic PowerPulsingEnable,
    input  logic AcqRequest,
    output logic PowerOnDigital,
    output logic PowerOnAnalog,
    output logic PowerOnDac,
    output logic PowerOnAdc,
    output logic PowerReady,
    output logic SeqBusy
);

    // Truncate to the counter width, then clamp a zero delay to a one-cycle dwell.
    function automatic logic [CNT_W-1:0] load_of(input int unsigned t);
        logic [CNT_W-1:0] tr;
        tr = CNT_W'(t);
        return (tr == '0) ? '0 : tr - CNT_W'(1);
    endfunction

    localparam logic [CNT_W-1:0] LD_DIG = load_of(T_DIG);
    localparam logic [CNT_W-1:0] LD_ANA = load_of(T_ANA);
    localparam logic [CNT_W-1:0] LD_DAC = load_of(T_DAC);
    localparam logic [CNT_W-1:0] LD_OFF = load_of(T_OFF);
`ifdef POWER_PULSING_ADC_EN
    localparam logic [CNT_W-1:0] LD_ADC = load_of(T_ADC);
`endif

    localparam bit TRUNC = ((T_DIG >> CNT_W) | (T_ANA >> CNT_W) | (T_DAC >> CNT_W) |
                            (T_ADC >> CNT_W) | (T_OFF >> CNT_W)) != 0;

    if (TRUNC) begin : g_trunc_warn
        $warning("power_pulsing_sequencer: a delay parameter exceeds CNT_W=%0d bits and is truncated", CNT_W);
    end

    pp_state_e        state, next_state;
    pp_out_t          out_q, out_next;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_done;

    pp_delay_counter #(.W(CNT_W)) u_delay (
        .clk  (Clk),
        .rst  (reset),
        .load (cnt_load),
        .value(cnt_value),
        .done (cnt_done)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        next_state = state;
        cnt_load   = 1'b0;
        cnt_value  = '0;
        if (!PowerPulsingEnable) begin
            next_state = ST_READY;
        end else begin
            case (state)
                ST_IDLE: if (AcqRequest) begin
                    next_state = ST_UP_DIG;
                    cnt_load   = 1'b1;
                    cnt_value  = LD_DIG;
                end
                ST_UP_DIG: if (!AcqRequest) begin
                    next_state = ST_OFF;
                    cnt_load   = 1'b1;
                    cnt_value  = LD_OFF;
                end else if (cnt_done) begin
                    next_state = ST_UP_ANA;
                    cnt_load   = 1'b1;
                    cnt_value  = LD_ANA;
                end
                ST_UP_ANA: if (!AcqRequest) begin
                    next_state = ST_OFF;
                    cnt_load   = 1'b1;
                    cnt_value  = LD_OFF;
                end else if (cnt_done) begin
                    next_state = ST_UP_DAC;
                    cnt_load   = 1'b1;
                    cnt_value  = LD_DAC;
                end
                ST_UP_DAC: if (!AcqRequest) begin
                    next_state = ST_OFF;
                    cnt_load   = 1'b1;
                    cnt_value  = LD_OFF;
                end else if (cnt_done) begin
`ifdef POWER_PULSING_ADC_EN
                    next_state = ST_UP_ADC;
                    cnt_load   = 1'b1;
                    cnt_value  = LD_ADC;
`else
                    next_state = ST_READY;
`endif
                end
`ifdef POWER_PULSING_ADC_EN
                ST_UP_ADC: if (!AcqRequest) begin
                    next_state = ST_OFF;
                    cnt_load   = 1'b1;
                    cnt_value  = LD_OFF;
                end else if (cnt_done) begin
                    next_state = ST_READY;
                end
`endif
                ST_READY: if (!AcqRequest) begin
                    next_state = ST_OFF;
                    cnt_load   = 1'b1;
                    cnt_value  = LD_OFF;
                end
                ST_OFF: if (cnt_done) begin
                    next_state = ST_IDLE;
                end
                default: next_state = ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, so they change with the state.
    always_comb begin
        out_next = outputs_of(next_state);
`ifndef POWER_PULSING_ADC_EN
        out_next.adc = ~PowerPulsingEnable;
`endif
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            out_q <= '0;
        end else begin
            state <= next_state;
            out_q <= out_next;
        end
    end

    assign PowerOnDigital = out_q.dig;
    assign PowerOnAnalog  = out_q.ana;
    assign PowerOnDac     = out_q.dac;
    assign PowerOnAdc     = out_q.adc;
    assign PowerReady     = out_q.ready;
    assign SeqBusy        = out_q.busy;

endmodule
